// File: rtl/pipeline_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, stall counter and flush.
// Define PIPE_SKID_EN to add a skid slot that registers in_ready (no out_ready -> in_ready path).
module pipeline_stage_hs #(
  parameter int unsigned CTRL_W       = 16,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ZERO_DATA_FL = 1,
  parameter int unsigned CLK_NEGEDGE  = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  // All state lives in one edge domain; the inversion selects the falling edge.
  logic clk_act;
  assign clk_act = (CLK_NEGEDGE != 0) ? ~clk : clk;

  logic              accept;
  logic              deliver;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign accept       = in_valid & in_ready & ~flush;
  assign deliver      = out_valid & out_ready;
  assign out_ctrl     = head_ctrl_q;
  assign out_data     = head_data_q;
  assign stall_cycles = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  always_ff @(posedge clk_act) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !deliver) begin
            state_d = StTwo;
          end else if (!accept && deliver) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (deliver) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
  end

  always_comb begin
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      head_ctrl_d = '0;
      if (ZERO_DATA_FL != 0) head_data_d = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end
        end
        StOne: begin
          if (accept && deliver) begin
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end
        end
        StTwo: begin
          if (deliver) begin
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
          end
        end
        default: ;
      endcase
    end
  end

`else
  logic valid_q, valid_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;

  always_ff @(posedge clk_act) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      stall_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      stall_q     <= stall_d;
    end
  end

  // Deliver without a refill only drops valid; the payload keeps its last value.
  always_comb begin
    valid_d     = valid_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    if (flush) begin
      valid_d     = 1'b0;
      head_ctrl_d = '0;
      if (ZERO_DATA_FL != 0) head_data_d = '0;
    end else if (accept) begin
      valid_d     = 1'b1;
      head_ctrl_d = in_ctrl;
      head_data_d = in_data;
    end else if (deliver) begin
      valid_d = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// Scoreboard bench for pipeline_stage_hs (falling-edge build, 4-bit stall counter).
module tb_pipeline_stage_hs;
  localparam int unsigned CtrlW    = 16;
  localparam int unsigned DataW    = 128;
  localparam int unsigned CntW     = 4;
  localparam int          StallMax = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CtrlW-1:0] in_ctrl = '0;
  logic [DataW-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CtrlW-1:0] out_ctrl;
  logic [DataW-1:0] out_data;
  logic [CntW-1:0]  stall_cycles;

  always #5 clk = ~clk;

  pipeline_stage_hs #(
    .CTRL_W      (CtrlW),
    .DATA_W      (DataW),
    .ZERO_DATA_FL(1),
    .CLK_NEGEDGE (1),
    .CNT_W       (CntW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_data    (out_data),
    .stall_cycles(stall_cycles)
  );

  logic [DataW-1:0] sbq[$];
  int               stall_m;
  bit               ctrl_zero;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check_eq(input string tag, input logic [DataW-1:0] got,
                          input logic [DataW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CtrlW-1:0] ctrl_of(input logic [DataW-1:0] d);
    return d[CtrlW-1:0] ^ 16'hC3C3;
  endfunction

  task automatic check_head(input string tag);
    check_eq({tag, "_valid"}, out_valid, sbq.size() != 0);
    if (sbq.size() != 0) begin
      check_eq({tag, "_data"}, out_data, sbq[0]);
      check_eq({tag, "_ctrl"}, out_ctrl, ctrl_of(sbq[0]));
    end else if (ctrl_zero) begin
      check_eq({tag, "_ctrl0"}, out_ctrl, 0);
      check_eq({tag, "_data0"}, out_data, 0);
    end
  endtask

  // Inputs change just after the rising edge; state moves on the falling edge.
  // Checks sit before and after the falling edge, so a rising-edge update is caught.
  task automatic cycle(input bit v, input logic [DataW-1:0] d, input bit ordy, input bit fl,
                       output bit acc);
    bit exp_rdy;
    bit dlv;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = ctrl_of(d);
    out_ready = ordy;
    flush     = fl;
    #2;
`ifdef PIPE_SKID_EN
    exp_rdy = sbq.size() < 2;
`else
    exp_rdy = (sbq.size() == 0) || ordy;
`endif
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("stall_cycles", stall_cycles, stall_m);
    check_head("pre_edge");
    acc = v && exp_rdy && !fl;
    dlv = (sbq.size() != 0) && ordy;
    if ((sbq.size() != 0) && !ordy && !fl && (stall_m < StallMax)) stall_m++;
    if (fl) begin
      sbq.delete();
      ctrl_zero = 1'b1;
    end else begin
      if (dlv) void'(sbq.pop_front());
      if (acc) begin
        sbq.push_back(d);
        ctrl_zero = 1'b0;
      end
    end
    @(negedge clk);
    #2;
    check_head("post_edge");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h5555;
    in_ctrl   = 16'hFFFF;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_ctrl", out_ctrl, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_stall", stall_cycles, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready, 1);
    sbq.delete();
    stall_m   = 0;
    ctrl_zero = 1'b1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 4; i++) begin
      if (sbq.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    end
  endtask

  initial begin
    bit               acc;
    bit               pv;
    logic [DataW-1:0] pd;
    int               seq;

    // Reset with in_valid asserted
    do_reset();

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) cycle(1'b1, DataW'(i), 1'b1, 1'b0, acc);
    drain();

    // Backpressure: 0xA accepted, 0xB offered while downstream stalls 5 cycles
    do_reset();
    cycle(1'b1, 128'hA, 1'b0, 1'b0, acc);
    pv = 1'b1;
    pd = 128'hB;
    for (int i = 0; i < 5; i++) begin
      cycle(pv, pd, 1'b0, 1'b0, acc);
      if (acc) pv = 1'b0;
    end
    check_eq("bp_stall5", stall_cycles, 5);
    check_eq("bp_head", out_data, 128'hA);
    for (int i = 0; i < 4; i++) begin
      cycle(pv, pd, 1'b1, 1'b0, acc);
      if (acc) pv = 1'b0;
    end
    drain();

    // Flush while full, with 0xC offered in the same cycle
    do_reset();
    cycle(1'b1, 128'hA, 1'b0, 1'b0, acc);
    cycle(1'b1, 128'hB, 1'b0, 1'b0, acc);
    cycle(1'b1, 128'hC, 1'b0, 1'b1, acc);
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ctrl", out_ctrl, 0);
    check_eq("flush_stall", stall_cycles, 1);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b1, 128'hD, 1'b1, 1'b0, acc);
    drain();

    // Saturation of the 4-bit stall counter
    do_reset();
    cycle(1'b1, 128'h11, 1'b0, 1'b0, acc);
    pv = 1'b1;
    pd = 128'h22;
    for (int i = 0; i < 20; i++) begin
      cycle(pv, pd, 1'b0, 1'b0, acc);
      if (acc) pv = 1'b0;
    end
    check_eq("sat_stall", stall_cycles, 15);
    cycle(pv, pd, 1'b0, 1'b0, acc);
    if (acc) pv = 1'b0;
    check_eq("sat_hold", stall_cycles, 15);
    for (int i = 0; i < 4; i++) begin
      cycle(pv, pd, 1'b1, 1'b0, acc);
      if (acc) pv = 1'b0;
    end
    drain();

    // Random traffic with occasional flushes
    do_reset();
    pv  = 1'b0;
    pd  = '0;
    seq = 100;
    for (int i = 0; i < 120; i++) begin
      bit ordy;
      bit fl;
      if (!pv && ($urandom_range(0, 2) != 0)) begin
        pv = 1'b1;
        pd = {$urandom(), $urandom(), $urandom(), 32'(seq)};
        seq++;
      end
      ordy = $urandom_range(0, 3) != 0;
      fl   = $urandom_range(0, 15) == 0;
      cycle(pv, pd, ordy, fl, acc);
      if (acc || fl) pv = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
